wb_burst_master: RTL
====================

Name: wb_burst_master

Overview:
- 128-bit Wishbone initiator that moves one multi-beat line between a requester (cache fill/writeback or DMA front end) and a burst-capable slave such as the scratch memory.
- Accepts a single line request, issues an incrementing-address burst (cti/bte), and collects or supplies one 128-bit word per ack.
- Reports completion, or a timeout error, with a one-cycle pulse.

Parameters:
- BEATS, 4, words per line (1..8); BEATS=1 issues a classic single cycle.
- TIMEOUT, 1023, consecutive cycles without ack_i before the burst is aborted.
- ADR_W, 32, byte address width.

Ports:
- rst_i  in  1  reset; asynchronous, active-high
- clk_i  in  1  single clock; all logic on rising edge
- req_i  in  1  request strobe; sampled only in IDLE
- req_we_i  in  1  1=line write, 0=line read
- req_adr_i  in  ADR_W  line byte address; bits [3:0] ignored
- req_dat_i  in  128*BEATS  write line, word k at bits [128k+127:128k]
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  valid with done_o; 1 = aborted on timeout
- rd_dat_o  out  128*BEATS  captured read line, same packing as req_dat_i
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  write enable
- cti_o  out  3  cycle type
- bte_o  out  2  burst type, always 2'b00 (linear)
- sel_o  out  16  byte selects, always 16'hFFFF during a cycle, 0 otherwise
- adr_o  out  ADR_W  beat byte address
- dat_o  out  128  write data
- ack_i  in  1  slave acknowledge
- dat_i  in  128  slave read data

Behaviour:
- Reset (async assert): state=IDLE. cyc_o, stb_o, we_o, done_o, err_o, busy_o = 0. cti_o=0, sel_o=0, adr_o=0, dat_o=0, rd_dat_o=0, beat=0, tmo=0.
- States:
  - IDLE -> RUN on req_i.
  - RUN -> DONE on final ack or on timeout.
  - DONE -> IDLE unconditionally after one cycle.
- On accept (edge where IDLE & req_i):
  - Latch request; beat=0; tmo=0.
  - Next cycle: cyc_o=stb_o=1, we_o=req_we_i, adr_o={req_adr_i[ADR_W-1:4],4'h0}, dat_o=word 0.
  - Request-to-cyc_o latency is 1 cycle.
- cti_o:
  - 3'b010 while beat < BEATS-1.
  - 3'b111 on beat BEATS-1.
  - 3'b000 throughout when BEATS=1.
- stb_o/cyc_o stay high continuously through the burst; no wait-state insertion by the master.
- Each edge with RUN & ack_i:
  - On a read, rd_dat_o word[beat] <= dat_i.
  - tmo <= 0.
  - If beat != BEATS-1: beat+1, adr_o+16, dat_o <= next word, cti_o updated in the same register stage.
  - If beat == BEATS-1: cyc_o, stb_o, we_o, sel_o, cti_o cleared on that edge; go to DONE.
- adr_o increments as a full ADR_W add; no wrap at line boundary (bte=linear).
- Timeout:
  - Each RUN cycle without ack_i increments tmo.
  - Edge where tmo==TIMEOUT-1 and no ack: drop the bus as on the last beat, set err flag, go to DONE.
  - Partially captured read words are retained.
- DONE: done_o=1 for exactly one cycle; err_o=err flag (cleared on next accept); busy_o=1. req_i in DONE is ignored.
- ack_i outside RUN is ignored; no capture, no state change.
- req_i while busy is ignored, not queued.
- Reset asserted mid-burst drops cyc_o/stb_o immediately (async) and discards the transfer; no done_o pulse.

Decomposition:
- Shared package wb_pkg: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111, BTE_LINEAR=2'b00, and enum burst_state_t {IDLE, RUN, DONE}.
- One sub-module is natural: wb_tmo_ctr (load-clear, count-enable, terminal flag at TIMEOUT-1), reusable by other initiators.
- Datapath and FSM stay in wb_burst_master.

Test Plan:
- Read, BEATS=4, req_adr_i=32'h0000_1238, slave acks every cycle from cycle 2 with dat_i=beat index:
  - adr_o sequence is 1230, 1240, 1250, 1260.
  - cti_o is 010, 010, 010, 111.
  - rd_dat_o words are 0..3.
  - done_o pulses once with err_o=0.
- Write, BEATS=4, slave inserting 2 wait cycles before each ack:
  - dat_o holds each word until its ack.
  - we_o=1 throughout; sel_o=FFFF.
  - cyc_o drops on the edge of the 4th ack.
- TIMEOUT=8, slave never acks:
  - cyc_o drops after 8 RUN cycles.
  - done_o=1, err_o=1.
  - A subsequent good request completes with err_o=0.
- BEATS=1 read at 32'h0000_0040: cti_o=000, single ack, rd_dat_o=dat_i, done_o one cycle later.
- Reset asserted mid-burst after the 2nd ack:
  - cyc_o/stb_o go 0 without a clock edge.
  - No done_o pulse.
  - busy_o=0.
  - req_i held high during busy and DONE is not re-accepted until IDLE.
- Read burst at 32'hFFFF_FFE0, BEATS=4: adr_o is FFE0, FFF0, then 0000_0000, 0000_0010 (full-width wrap), completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type and burst-type encodings, the
// 128-bit word geometry, and the burst initiator state type.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam int WORD_W     = 128;
  localparam int WORD_BYTES = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } burst_state_t;

endpackage

// File: rtl/wb_tmo_ctr.sv
// Wait-for-ack watchdog: counts consecutive enabled cycles and flags the
// cycle in which the count has reached TIMEOUT-1. Clear has priority.
module wb_tmo_ctr #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TC_VAL);

  // Next count: clear wins, otherwise step up and hold at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// 128-bit Wishbone burst initiator: moves one BEATS-word line per request
// with a linear incrementing burst, and signals completion or timeout.
//
//   state | meaning
//   IDLE  | bus released, waiting for req_i
//   RUN   | cyc/stb asserted, one word per ack, watchdog running
//   DONE  | one-cycle done_o pulse, err_o reports a timeout abort
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 1023,
  parameter int ADR_W   = 32
) (
  input  logic                    rst_i,
  input  logic                    clk_i,
  input  logic                    req_i,
  input  logic                    req_we_i,
  input  logic [ADR_W-1:0]        req_adr_i,
  input  logic [WORD_W*BEATS-1:0] req_dat_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [WORD_W*BEATS-1:0] rd_dat_o,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic                    we_o,
  output logic [2:0]              cti_o,
  output logic [1:0]              bte_o,
  output logic [15:0]             sel_o,
  output logic [ADR_W-1:0]        adr_o,
  output logic [WORD_W-1:0]       dat_o,
  input  logic                    ack_i,
  input  logic [WORD_W-1:0]       dat_i
);

  localparam int LINE_W = WORD_W * BEATS;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  // A single-beat line is a classic cycle; otherwise the first beat is incrementing.
  localparam logic [2:0] CTI_FIRST = (BEATS == 1) ? CTI_CLASSIC : CTI_INCR;

  burst_state_t      state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] rd_q, rd_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [2:0]        cti_q, cti_d;
  logic              err_q, err_d;

  logic tmo_clr, tmo_en, tmo_tc;
  logic adr_lo_unused;

  // Line addresses are 16-byte aligned; the low nibble of the request is dropped.
  assign adr_lo_unused = ^req_adr_i[3:0];

  assign tmo_clr = ((state_q == IDLE) && req_i) || ((state_q == RUN) && ack_i);
  assign tmo_en  = (state_q == RUN) && !ack_i;

  wb_tmo_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tmo_clr),
    .en_i  (tmo_en),
    .tc_o  (tmo_tc)
  );

  // Next-state and datapath updates. line_q holds the not-yet-sent words,
  // shifted down one word per ack so dat_o is always its bottom word.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    adr_d   = adr_q;
    line_d  = line_q;
    rd_d    = rd_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    cti_d   = cti_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = RUN;
          beat_d  = '0;
          adr_d   = {req_adr_i[ADR_W-1:4], 4'h0};
          line_d  = req_dat_i;
          cyc_d   = 1'b1;
          we_d    = req_we_i;
          cti_d   = CTI_FIRST;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (ack_i) begin
          if (!we_q) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_q == BW'(k)) begin
                rd_d[k*WORD_W +: WORD_W] = dat_i;
              end
            end
          end
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            cti_d   = CTI_CLASSIC;
          end else begin
            beat_d = beat_q + 1'b1;
            adr_d  = adr_q + ADR_W'(WORD_BYTES);
            line_d = line_q >> WORD_W;
            cti_d  = (BW'(beat_q + 1'b1) == LAST_BEAT) ? CTI_EOB : CTI_INCR;
          end
        end else if (tmo_tc) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          cti_d   = CTI_CLASSIC;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      adr_q   <= '0;
      line_q  <= '0;
      rd_q    <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      adr_q   <= adr_d;
      line_q  <= line_d;
      rd_q    <= rd_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      cti_q   <= cti_d;
      err_q   <= err_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign err_o    = (state_q == DONE) && err_q;
  assign rd_dat_o = rd_q;
  assign cyc_o    = cyc_q;
  assign stb_o    = cyc_q;
  assign we_o     = we_q;
  assign cti_o    = cti_q;
  assign bte_o    = BTE_LINEAR;
  assign sel_o    = cyc_q ? 16'hFFFF : 16'h0000;
  assign adr_o    = adr_q;
  assign dat_o    = line_q[WORD_W-1:0];

endmodule
